sin_tone_gen: RTL and testbench
===============================

SIN_TONE_GEN -- requirements
Module: sin_tone_gen

Interface
REQ-001 Parameter PHASE_W, 16, phase-accumulator and step width in bits.
REQ-002 Parameter LUT_AW, 6, quarter-wave table address width (64 entries).
REQ-003 iCLK  in  1  system clock; only clock, all logic on its rising edge.
REQ-004 iRST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 iSin_CLK  in  1  divided sample-rate clock, treated as data and sampled in the iCLK domain.
REQ-006 isound_off1  in  1  mutes voice 1 when high.
REQ-007 isound_off2  in  1  mutes voice 2 when high.
REQ-008 iStep1  in  PHASE_W  voice 1 phase increment per sample.
REQ-009 iStep2  in  PHASE_W  voice 2 phase increment per sample.
REQ-010 oSample  out  16  signed two's-complement mixed sample.
REQ-011 oSample_valid  out  1  oSample holds a new sample.
REQ-012 iSample_ready  in  1  downstream accepts the sample when high with oSample_valid.
REQ-013 oOverrun  out  1  sticky flag: a sample tick was dropped.

Function
REQ-014 iSin_CLK SHALL pass through a 3-flop chain s1->s2->s3; tick = s2 AND NOT s3, one iCLK cycle per rising edge.
REQ-015 FSM states: IDLE, LOOK1, LOOK2, HOLD; reset state IDLE.
REQ-016 IDLE with tick: phase1 += iStep1, phase2 += iStep2 (mod 2^PHASE_W), mute1/mute2 registered from isound_off1/2, next state LOOK1; IDLE without tick: no change.
REQ-017 LOOK1: voice1 computed from updated phase1, registered; next LOOK2.
REQ-018 LOOK2: voice2 computed from updated phase2; oSample <= voice1 + voice2; oSample_valid <= 1; next HOLD.
REQ-019 HOLD: oSample and oSample_valid stable until iSample_ready=1, then oSample_valid <= 0 and next IDLE.
REQ-020 Latency: with ready held high, oSample_valid rises at cycle T+3 (T = cycle tick is high) and stays high exactly one cycle.
REQ-021 Lookup: index = phase[PHASE_W-1:PHASE_W-8]; quadrant q = index[7:6], a = index[5:0].
REQ-022 Table address = a for q=0,2 and 63-a for q=1,3; magnitude m = LUT[address].
REQ-023 LUT[k] = round(16383 * sin(pi/2 * (k+0.5)/64)), unsigned 14-bit; LUT[0]=201, LUT[63]=16383.
REQ-024 Voice value = +m for q=0,1, -m for q=2,3, sign-extended to 16 bits; forced 0 when its mute bit is set.
REQ-025 Sum range is +/-32766; no saturation logic required, no overflow possible.
REQ-026 Muted voices still advance phase.
REQ-027 Tick in any state other than IDLE: tick dropped, phases unchanged, oOverrun set to 1; oOverrun cleared only by reset.
REQ-028 iStep and isound_off are sampled only in the IDLE-with-tick cycle; changes elsewhere have no effect on the in-flight sample.
REQ-029 Step 0 yields a constant sample; step 2^(PHASE_W-1) alternates quadrants 0/2.

Reset
REQ-030 On iRST_N low, immediately: state IDLE, phase1=phase2=0, mute bits 0, voice1 register 0, oSample=0, oSample_valid=0, oOverrun=0.
REQ-031 s1, s2, s3 reset to 1, so iSin_CLK high at reset release generates no tick.
REQ-032 Reset mid-sample discards the sample; first tick after release restarts from phase 0.

Structure
REQ-033 Shared package: PHASE_W and LUT_AW defaults, FSM state encoding, LUT magnitude constant 16383.
REQ-034 One sub-module sine_quarter_lut: combinational 64x14 ROM, address in, magnitude out; quadrant folding and sign stay in sin_tone_gen.

Verification
REQ-035 iStep1=0x4000, isound_off2=1, ready=1, four ticks -> oSample = +16383, -201, -16383, +201.
REQ-036 iStep1=iStep2=0x4000, both unmuted, one tick -> oSample=+32766, valid at T+3 for one cycle.
REQ-037 isound_off1=isound_off2=1, any steps, one tick -> oSample=0; a further unmuted tick shows the phase advanced twice.
REQ-038 ready=0 after first tick, second tick at T+6 -> oSample held, oOverrun=1, raising ready then a tick gives phase advanced only once.
REQ-039 iSin_CLK high through reset release -> no valid until a subsequent 0->1 edge; assert iRST_N low in LOOK2 -> valid 0, phase 0.
REQ-040 iStep1=0xFFFF, 65536 ticks -> phase1 wraps to 0 exactly.

Source files
------------

// File: rtl/sin_tone_gen_pkg.sv
// Shared definitions for the two-voice sine tone generator: default widths,
// FSM state encoding, table full-scale value and small lookup helpers.
package sin_tone_gen_pkg;

  localparam int PHASE_W_DEF = 16;
  localparam int LUT_AW_DEF  = 6;
  localparam int MAG_W       = 14;
  localparam int SAMPLE_W    = 16;

  // Full-scale quarter-wave magnitude (top table entry).
  localparam logic [MAG_W-1:0] LUT_MAG_MAX = 14'd16383;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOOK1 = 2'd1,
    LOOK2 = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Quadrants 1 and 3 run the quarter table backwards; 63-a equals ~a.
  function automatic logic [LUT_AW_DEF-1:0] fold_addr(input logic [1:0]            quad,
                                                      input logic [LUT_AW_DEF-1:0] a);
    return quad[0] ? ~a : a;
  endfunction

  // Applies the half-wave sign and the mute to a table magnitude.
  function automatic logic signed [SAMPLE_W-1:0] signed_voice(input logic [1:0]       quad,
                                                              input logic [MAG_W-1:0] mag,
                                                              input logic             mute);
    logic signed [SAMPLE_W-1:0] v;
    v = signed'({{(SAMPLE_W-MAG_W){1'b0}}, mag});
    if (mute) begin
      v = '0;
    end else if (quad[1]) begin
      v = -v;
    end
    return v;
  endfunction

endpackage

// File: rtl/sin_tone_gen_quarter_lut.sv
// Quarter-wave sine magnitude ROM: 64 entries of 14 bits, sampled at the
// centre of each address bin; the last entry is exact full scale.
module sine_quarter_lut
  import sin_tone_gen_pkg::*;
(
  input  logic [LUT_AW_DEF-1:0] addr,
  output logic [MAG_W-1:0]      mag
);

  // NOTE: a constant ROM holds no state, so it has no clock and no reset.
  localparam logic [MAG_W-1:0] ROM [0:63] = '{
    14'd201,   14'd603,   14'd1005,  14'd1406,  14'd1806,  14'd2205,  14'd2603,  14'd2999,
    14'd3393,  14'd3785,  14'd4175,  14'd4563,  14'd4948,  14'd5330,  14'd5708,  14'd6083,
    14'd6455,  14'd6822,  14'd7186,  14'd7545,  14'd7900,  14'd8249,  14'd8594,  14'd8934,
    14'd9268,  14'd9597,  14'd9920,  14'd10237, 14'd10548, 14'd10852, 14'd11150, 14'd11441,
    14'd11726, 14'd12003, 14'd12273, 14'd12536, 14'd12791, 14'd13038, 14'd13278, 14'd13509,
    14'd13733, 14'd13948, 14'd14154, 14'd14353, 14'd14542, 14'd14723, 14'd14895, 14'd15058,
    14'd15212, 14'd15356, 14'd15492, 14'd15618, 14'd15735, 14'd15842, 14'd15940, 14'd16028,
    14'd16106, 14'd16175, 14'd16234, 14'd16283, 14'd16323, 14'd16352, 14'd16372, LUT_MAG_MAX
  };

  assign mag = ROM[addr];

endmodule

// File: rtl/sin_tone_gen.sv
// Two-voice sine tone generator. Each sample tick advances both phase
// accumulators, looks each voice up through one shared quarter-wave ROM over
// two cycles, and presents the sum with a valid/ready handshake.
module sin_tone_gen
  import sin_tone_gen_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int LUT_AW  = LUT_AW_DEF
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic                       iSin_CLK,
  input  logic                       isound_off1,
  input  logic                       isound_off2,
  input  logic [PHASE_W-1:0]         iStep1,
  input  logic [PHASE_W-1:0]         iStep2,
  output logic signed [SAMPLE_W-1:0] oSample,
  output logic                       oSample_valid,
  input  logic                       iSample_ready,
  output logic                       oOverrun
);

  localparam int IDX_W = LUT_AW + 2;

  logic                       s1, s2, s3;
  logic                       tick;
  state_e                     state;
  logic [PHASE_W-1:0]         phase1, phase2;
  logic                       mute1, mute2;
  logic signed [SAMPLE_W-1:0] voice1_q;

  logic [PHASE_W-1:0]         lk_phase;
  logic                       lk_mute;
  logic [IDX_W-1:0]           lk_idx;
  logic [1:0]                 lk_quad;
  logic [LUT_AW-1:0]          lk_addr;
  logic [MAG_W-1:0]           lk_mag;
  logic signed [SAMPLE_W-1:0] lk_voice;

  // Bring the sample-rate clock into the iCLK domain; s2/s3 form the edge detector.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= iSin_CLK;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  // Pick which voice uses the shared ROM: voice 2 in LOOK2, voice 1 otherwise.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lk_phase = phase1;
    lk_mute  = mute1;
    if (state == LOOK2) begin
      lk_phase = phase2;
      lk_mute  = mute2;
    end
  end

  assign lk_idx   = lk_phase[PHASE_W-1 -: IDX_W];
  assign lk_quad  = lk_idx[IDX_W-1 -: 2];
  assign lk_addr  = fold_addr(lk_quad, lk_idx[LUT_AW-1:0]);
  assign lk_voice = signed_voice(lk_quad, lk_mag, lk_mute);

  sine_quarter_lut u_lut (
    .addr (lk_addr),
    .mag  (lk_mag)
  );

  // Sample sequencer: advance phases, look up both voices, mix and hold for the consumer.
  // NOTE: non-blocking assignments so every register sees the pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state         <= IDLE;
      phase1        <= '0;
      phase2        <= '0;
      mute1         <= 1'b0;
      mute2         <= 1'b0;
      voice1_q      <= '0;
      oSample       <= '0;
      oSample_valid <= 1'b0;
      oOverrun      <= 1'b0;
    end else begin
      if (tick && (state != IDLE)) begin
        oOverrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            phase1 <= phase1 + iStep1;
            phase2 <= phase2 + iStep2;
            mute1  <= isound_off1;
            mute2  <= isound_off2;
            state  <= LOOK1;
          end
        end
        LOOK1: begin
          voice1_q <= lk_voice;
          state    <= LOOK2;
        end
        LOOK2: begin
          oSample       <= voice1_q + lk_voice;
          oSample_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (iSample_ready) begin
            oSample_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sin_tone_gen.sv
// Self-checking bench for sin_tone_gen: a transaction-level reference model
// (real-valued sine table, integer phases, handshake timing) is compared with
// the DUT every cycle, alongside directed literal expectations.
module tb_sin_tone_gen;

  logic               iCLK = 1'b0;
  logic               iRST_N = 1'b0;
  logic               iSin_CLK = 1'b1;
  logic               isound_off1 = 1'b0;
  logic               isound_off2 = 1'b0;
  logic [15:0]        iStep1 = '0;
  logic [15:0]        iStep2 = '0;
  logic signed [15:0] oSample;
  logic               oSample_valid;
  logic               iSample_ready;
  logic               oOverrun;

  logic ready_dir = 1'b1;
  logic ready_rnd = 1'b1;
  logic ready_sel = 1'b0;
  assign iSample_ready = ready_sel ? ready_rnd : ready_dir;

  int n_checks = 0;
  int n_errors = 0;

  sin_tone_gen dut (
    .iCLK          (iCLK),
    .iRST_N        (iRST_N),
    .iSin_CLK      (iSin_CLK),
    .isound_off1   (isound_off1),
    .isound_off2   (isound_off2),
    .iStep1        (iStep1),
    .iStep2        (iStep2),
    .oSample       (oSample),
    .oSample_valid (oSample_valid),
    .iSample_ready (iSample_ready),
    .oOverrun      (oOverrun)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int lut_m [64];

  initial begin
    for (int k = 0; k < 64; k++) begin
      lut_m[k] = $rtoi(16383.0 * $sin(3.14159265358979 * (k + 0.5) / 128.0) + 0.5);
    end
    lut_m[63] = 16383;  // top entry is defined as exact full scale
  end

  function automatic int voice_of(input int phase, input bit mute);
    int idx, q, a, m;
    if (mute) return 0;
    idx = phase / 256;
    q   = idx / 64;
    a   = idx % 64;
    m   = (q == 1 || q == 3) ? lut_m[63 - a] : lut_m[a];
    return (q >= 2) ? -m : m;
  endfunction

  int unsigned m_edge = 0;
  int unsigned m_acc = 0;
  bit m_sin_prev = 1'b1;
  bit m_rise_d1 = 1'b0, m_rise_d2 = 1'b0;
  bit m_busy = 1'b0, m_ovr = 1'b0;
  bit m_tick, m_rise, m_busy_pre;
  int m_ph1 = 0, m_ph2 = 0, m_pending = 0, m_sample = 0;

  // A rising iSin_CLK first captured at edge n is acted on at edge n+2; an accepted
  // tick's sum appears two edges later and stays until an edge with ready high.
  initial forever begin
    @(posedge iCLK or negedge iRST_N);
    if (!iRST_N) begin
      m_sin_prev = 1'b1; m_rise_d1 = 1'b0; m_rise_d2 = 1'b0;
      m_busy = 1'b0; m_ovr = 1'b0; m_ph1 = 0; m_ph2 = 0; m_sample = 0; m_pending = 0;
    end else begin
      m_edge++;
      m_rise     = iSin_CLK && !m_sin_prev;
      m_sin_prev = iSin_CLK;
      m_tick     = m_rise_d2;
      m_rise_d2  = m_rise_d1;
      m_rise_d1  = m_rise;
      m_busy_pre = m_busy;
      if (m_busy_pre && m_edge == m_acc + 2) m_sample = m_pending;
      if (m_busy_pre && m_edge >= m_acc + 3 && iSample_ready) m_busy = 1'b0;
      if (m_tick) begin
        if (m_busy_pre) begin
          m_ovr = 1'b1;
        end else begin
          m_ph1     = (m_ph1 + int'(iStep1)) % 65536;
          m_ph2     = (m_ph2 + int'(iStep2)) % 65536;
          m_pending = voice_of(m_ph1, isound_off1) + voice_of(m_ph2, isound_off2);
          m_acc     = m_edge;
          m_busy    = 1'b1;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge iCLK);
    #1;
    check("valid",   int'(oSample_valid), int'(m_busy && (m_edge >= m_acc + 2)));
    check("sample",  int'(oSample), m_sample);
    check("overrun", int'(oOverrun), int'(m_ovr));
  end

  initial forever begin
    @(negedge iCLK);
    ready_rnd = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus ----------------
  task automatic expect_tick(input string name, input int exp);
    int n;
    @(negedge iCLK);
    iSin_CLK = 1'b1;
    n = 0;
    do begin
      @(negedge iCLK);
      n++;
      if (n == 2) iSin_CLK = 1'b0;
    end while (!oSample_valid && n < 20);
    iSin_CLK = 1'b0;
    check({name, " valid"}, int'(oSample_valid), 1);
    check(name, int'(oSample), exp);
    repeat (3) @(negedge iCLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] vbits;

    // Reset with iSin_CLK high, released while still high: no tick may follow.
    repeat (3) @(negedge iCLK);
    check("reset sample",  int'(oSample), 0);
    check("reset valid",   int'(oSample_valid), 0);
    check("reset overrun", int'(oOverrun), 0);
    iRST_N = 1'b1;
    repeat (8) @(negedge iCLK);
    check("no tick at release", int'(oSample_valid), 0);
    iSin_CLK = 1'b0;
    repeat (3) @(negedge iCLK);

    // Single voice, quarter-cycle steps.
    iStep1 = 16'h4000; isound_off1 = 1'b0; isound_off2 = 1'b1;
    expect_tick("q1 peak",   16383);
    expect_tick("q2 start",  -201);
    expect_tick("q3 peak",   -16383);
    expect_tick("q0 start",  201);

    // Both voices at peak; valid exactly one cycle, five negedges after the rise.
    iStep2 = 16'h4000; isound_off2 = 1'b0;
    @(negedge iCLK);
    iSin_CLK = 1'b1;
    vbits = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge iCLK);
      if (c == 2) iSin_CLK = 1'b0;
      vbits[c-1] = oSample_valid;
      if (c == 5) check("dual peak", int'(oSample), 32766);
    end
    check("dual latency", int'(vbits), 16);
    repeat (2) @(negedge iCLK);

    // Muted tick still advances phases.
    iStep1 = 16'h2000; iStep2 = 16'h2000; isound_off1 = 1'b1; isound_off2 = 1'b1;
    expect_tick("both muted", 0);
    isound_off1 = 1'b0; isound_off2 = 1'b0;
    expect_tick("after mute", -402);

    // Backpressure: second tick is dropped and flagged.
    iStep1 = 16'h4000; iStep2 = 16'h4000; ready_dir = 1'b0;
    expect_tick("held sample", -32766);
    iSin_CLK = 1'b1;
    repeat (2) @(negedge iCLK);
    iSin_CLK = 1'b0;
    repeat (4) @(negedge iCLK);
    check("hold valid",   int'(oSample_valid), 1);
    check("hold sample",  int'(oSample), -32766);
    check("overrun flag", int'(oOverrun), 1);
    ready_dir = 1'b1;
    repeat (2) @(negedge iCLK);
    check("released valid", int'(oSample_valid), 0);
    expect_tick("single advance", 402);

    // Reset while the FSM is in LOOK2 discards the sample.
    @(negedge iCLK);
    iSin_CLK = 1'b1;
    repeat (2) @(negedge iCLK);
    iSin_CLK = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    check("mid reset valid",   int'(oSample_valid), 0);
    check("mid reset sample",  int'(oSample), 0);
    check("mid reset overrun", int'(oOverrun), 0);
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (3) @(negedge iCLK);

    // Phase restarts at 0 and wraps modulo 2^16.
    isound_off2 = 1'b1;
    iStep1 = 16'hFFFF;
    expect_tick("wrap down", -201);
    iStep1 = 16'h0001;
    expect_tick("wrap up", 201);
    iStep1 = 16'h4000;
    expect_tick("after wrap", 16383);

    // Randomized traffic: steps, mutes, tick spacing and ready all vary.
    ready_sel = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 5))
          0:       iStep1 = 16'h0000;
          1:       iStep1 = 16'h8000;
          default: iStep1 = 16'($urandom);
        endcase
        iStep2 = 16'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        isound_off1 = 1'($urandom);
        isound_off2 = 1'($urandom);
      end
      @(negedge iCLK);
      iSin_CLK = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge iCLK);
      if ($urandom_range(0, 3) == 0) iStep1 = 16'($urandom);
      iSin_CLK = 1'b0;
      repeat ($urandom_range(1, 8)) @(negedge iCLK);
    end
    ready_sel = 1'b0;
    ready_dir = 1'b1;
    repeat (20) @(negedge iCLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
